display_scan_ctrl: RTL

DISPLAY_SCAN_CTRL -- requirements
Module: display_scan_ctrl

---
 rtl/display_scan_ctrl_pkg.sv | 29 ++
 rtl/display_scan_ctrl_bcd_a_7seg.sv | 17 +
 rtl/display_scan_ctrl.sv | 129 ++++++++++++
 3 files changed

// File: rtl/display_scan_ctrl_pkg.sv
// Shared types and constants for the four-digit multiplexed 7-segment scanner.
package display_scan_ctrl_pkg;

    // Scanner operating modes: dark or cycling through the digits
    typedef enum logic {
        APAGADO = 1'b0,
        ESCANEO = 1'b1
    } estado_t;

    // Active-low patterns, bit 0 = segment a ... bit 6 = segment g
    localparam logic [6:0] SEG_GUION   = 7'b0111111;
    localparam logic [6:0] SEG_BLANCO  = 7'b1111111;
    localparam logic [3:0] DIG_APAGADO = 4'b1111;

    // Decimal digits 0..9, index 0 is the leftmost entry
    localparam logic [0:9][6:0] SEG_TABLA = {
        7'b1000000,  // 0
        7'b1111001,  // 1
        7'b0100100,  // 2
        7'b0110000,  // 3
        7'b0011001,  // 4
        7'b0010010,  // 5
        7'b0000010,  // 6
        7'b1111000,  // 7
        7'b0000000,  // 8
        7'b0010000   // 9
    };

endpackage

// File: rtl/display_scan_ctrl_bcd_a_7seg.sv
// BCD nibble to active-low 7-segment pattern; non-decimal codes show a dash.
module bcd_a_7seg
    import display_scan_ctrl_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    // Table lookup for 0..9, dash for anything else
    always_comb begin
        seg = SEG_GUION;
        if (bcd <= 4'd9) begin
            seg = SEG_TABLA[bcd];
        end
    end

endmodule

// File: rtl/display_scan_ctrl.sv
// Four-digit multiplexed 7-segment scan controller with double-buffered value
// (pendiente -> mostrado swap only at frame boundaries) and leading-zero blanking.
module display_scan_ctrl
    import display_scan_ctrl_pkg::*;
#(
    parameter int DIV = 50000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        habilitar,
    input  logic [15:0] valor,
    input  logic        cargar,
    input  logic        blanco_ceros,
    output logic        listo,
    output logic [3:0]  digito,
    output logic [6:0]  segmentos
);

    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;

    estado_t        estado, estado_sig;
    logic [PW-1:0]  presc;
    logic [1:0]     idx;
    logic           tick;
    logic           fin_cuadro;
    logic [15:0]    pendiente;
    logic [15:0]    mostrado;
    logic [3:0]     nibble;
    logic [6:0]     seg_cod;
    logic           blanco;

    assign tick       = (estado == ESCANEO) && (presc == PW'(DIV - 1));
    assign fin_cuadro = tick && (idx == 2'd3);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            estado <= APAGADO;
        end else begin
            estado <= estado_sig;
        end
    end

    // Next-state logic: habilitar alone selects scanning or dark
    always_comb begin
        estado_sig = estado;
        case (estado)
            APAGADO: if (habilitar)  estado_sig = ESCANEO;
            ESCANEO: if (!habilitar) estado_sig = APAGADO;
            default: estado_sig = APAGADO;
        endcase
    end

    // Prescaler and digit index; cleared whenever not (staying) in scan so a
    // re-enable always restarts at digit 0
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc <= '0;
            idx   <= 2'd0;
        end else if ((estado == ESCANEO) && habilitar) begin
            if (tick) begin
                presc <= '0;
                idx   <= idx + 2'd1;
            end else begin
                presc <= presc + PW'(1);
            end
        end else begin
            presc <= '0;
            idx   <= 2'd0;
        end
    end

    // Double buffer: swap takes priority over a coincident load
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pendiente <= 16'h0000;
            mostrado  <= 16'h0000;
            listo     <= 1'b1;
        end else if (!listo && ((estado == APAGADO) || fin_cuadro)) begin
            mostrado <= pendiente;
            listo    <= 1'b1;
        end else if (cargar && listo) begin
            pendiente <= valor;
            listo     <= 1'b0;
        end
    end

    // Nibble and blanking decision for the currently selected digit
    always_comb begin
        nibble = mostrado[3:0];
        blanco = 1'b0;
        case (idx)
            2'd0: nibble = mostrado[3:0];
            2'd1: begin
                nibble = mostrado[7:4];
                blanco = (mostrado[15:4] == 12'h000);
            end
            2'd2: begin
                nibble = mostrado[11:8];
                blanco = (mostrado[15:8] == 8'h00);
            end
            default: begin
                nibble = mostrado[15:12];
                blanco = (mostrado[15:12] == 4'h0);
            end
        endcase
        blanco = blanco && blanco_ceros;
    end

    bcd_a_7seg u_bcd (
        .bcd (nibble),
        .seg (seg_cod)
    );

    // Registered digit/segment drivers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            digito    <= DIG_APAGADO;
            segmentos <= SEG_BLANCO;
        end else if (estado == ESCANEO) begin
            digito    <= ~(4'b0001 << idx);
            segmentos <= blanco ? SEG_BLANCO : seg_cod;
        end else begin
            digito    <= DIG_APAGADO;
            segmentos <= SEG_BLANCO;
        end
    end

endmodule
